// File: rtl/spi_wb_bridge_pkg.sv
// Shared constants for the SPI-slave to Wishbone-master bridge: FSM state encoding,
// command-byte layout and field lengths.
package spi_wb_bridge_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_CMD      = 4'd1;
    localparam state_t ST_ADDR     = 4'd2;
    localparam state_t ST_WR_DATA  = 4'd3;
    localparam state_t ST_WB_WR    = 4'd4;
    localparam state_t ST_RD_WB    = 4'd5;
    localparam state_t ST_RD_DUMMY = 4'd6;
    localparam state_t ST_RD_DATA  = 4'd7;
    localparam state_t ST_WAIT_CS  = 4'd8;

    localparam int CMD_BITS     = 8;
    localparam int CMD_RD_BIT   = 7;
    localparam int CMD_SEL_MSB  = 3;
    localparam int CMD_RSVD_MSB = 6;
    localparam int CMD_RSVD_LSB = 4;
    localparam int DUMMY_BITS   = 8;
    localparam int DATA_BITS    = 32;

    localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;

    // True on the last bit of a field that is 'width' bits long.
    function automatic logic field_end(input logic [5:0] cnt, input int width);
        return cnt == 6'(width - 1);
    endfunction

endpackage

// File: rtl/spi_wb_bridge_sync.sv
// Two-flop synchronizer with a third flop for edge detection; pulses are one clk wide.
module spi_wb_bridge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) sh_q <= {3{RST_VAL}};
        else     sh_q <= {sh_q[1:0], a_i};
    end

    assign lvl_o  = sh_q[1];
    assign rise_o =  sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave that turns each CMD/ADDR/DATA frame into one classic Wishbone cycle.
// Optional watchdog on the Wishbone cycle: define SPI_WB_BRIDGE_TIMEOUT_EN.
module spi_wb_bridge
    import spi_wb_bridge_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              busy_o,
    output logic              err_o
);

    if ((ADDR_W != 16 && ADDR_W != 24) || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_param
        $error("spi_wb_bridge: unsupported ADDR_W or TIMEOUT_CYC");
    end

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_wb_bridge_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .a_i(spi_sclk_i),
        .lvl_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_wb_bridge_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .a_i(spi_cs_n_i),
        .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_wb_bridge_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .a_i(spi_mosi_i),
        .lvl_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [31:0]       sh_q, sh_d, sh_in;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              rd_q, rd_d, cyc_q, cyc_d, err_q, err_d;
    logic              miso_q, miso_d, gone_q, gone_d;
    logic              timeout, wb_done, wb_bad;

`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
    logic [7:0] wdog_q;

    // Held at zero between cycles, so every new cycle starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || !cyc_q) wdog_q <= 8'd0;
        else               wdog_q <= wdog_q + 8'd1;
    end

    assign timeout = cyc_q && (wdog_q == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign sh_in   = {sh_q[30:0], mosi_lvl};
    assign wb_done = cyc_q & (wb_ack_i | wb_err_i | timeout);
    assign wb_bad  = cyc_q & (wb_err_i | timeout);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        miso_d  = miso_q;
        gone_d  = gone_q;

        if (wb_done) cyc_d = 1'b0;
        if (wb_bad)  err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && !cyc_q) begin
                    state_d = ST_CMD;
                    cnt_d   = 6'd0;
                    err_d   = 1'b0;
                    miso_d  = 1'b0;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q + 6'd1;
                    if (field_end(cnt_q, CMD_BITS)) begin
                        cnt_d = 6'd0;
                        rd_d  = sh_in[CMD_RD_BIT];
                        sel_d = sh_in[CMD_SEL_MSB:0];
                        if (|sh_in[CMD_RSVD_MSB:CMD_RSVD_LSB]) begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_CS;
                        end else begin
                            state_d = ST_ADDR;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q + 6'd1;
                    if (field_end(cnt_q, ADDR_W)) begin
                        cnt_d = 6'd0;
                        adr_d = sh_in[ADDR_W-1:0];
                        if (rd_q) begin
                            cyc_d   = 1'b1;
                            gone_d  = 1'b0;
                            state_d = ST_RD_WB;
                        end else begin
                            state_d = ST_WR_DATA;
                        end
                    end
                end
            end
            ST_WR_DATA: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q + 6'd1;
                    if (field_end(cnt_q, DATA_BITS)) begin
                        cnt_d   = 6'd0;
                        dat_d   = sh_in;
                        cyc_d   = 1'b1;
                        gone_d  = 1'b0;
                        state_d = ST_WB_WR;
                    end
                end
            end
            ST_WB_WR: begin
                if (cs_rise) gone_d = 1'b1;
                if (wb_done) state_d = (gone_q || cs_rise) ? ST_IDLE : ST_WAIT_CS;
            end
            ST_RD_WB: begin
                // Dummy bits keep counting while the slave works; a frame that has already
                // ended only waits here for the cycle to finish.
                if (cs_rise) gone_d = 1'b1;
                if (wb_done) sh_d = wb_bad ? RD_ERR_DATA : wb_dat_i;
                if (sclk_rise && !gone_q) cnt_d = cnt_q + 6'd1;
                if (wb_done && (gone_q || cs_rise)) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise && !gone_q && field_end(cnt_q, DUMMY_BITS)) begin
                    cnt_d   = 6'd0;
                    state_d = ST_RD_DATA;
                    if (!wb_done) begin
                        sh_d  = RD_ERR_DATA;
                        err_d = 1'b1;
                    end
                end else if (wb_done) begin
                    state_d = ST_RD_DUMMY;
                end
            end
            ST_RD_DUMMY: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 6'd1;
                    if (field_end(cnt_q, DUMMY_BITS)) begin
                        cnt_d   = 6'd0;
                        state_d = ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sclk_fall) begin
                        miso_d = sh_q[31];
                        sh_d   = {sh_q[30:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 6'd1;
                        if (field_end(cnt_q, DATA_BITS)) begin
                            cnt_d   = 6'd0;
                            state_d = ST_WAIT_CS;
                        end
                    end
                end
            end
            ST_WAIT_CS: begin
                if (cs_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame that starts while the previous cycle is still open is dropped.
        if (cs_fall && cyc_q) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            adr_q   <= '0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            rd_q    <= 1'b0;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
            miso_q  <= 1'b0;
            gone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            miso_q  <= miso_d;
            gone_q  <= gone_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign wb_we_o       = cyc_q & ~rd_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;
    assign busy_o        = cyc_q;
    assign err_o         = err_q;
    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = ~cs_lvl;

endmodule

// File: doc/spi_wb_bridge.md
# spi_wb_bridge

SPI-slave to Wishbone-master bridge forming the front end of subsystem block 2. An external SPI master sends command/address/data frames. The bridge turns each frame into one classic single Wishbone read or write toward the block-2 register fabric, and returns read data on MISO in the same frame.

## Interface
- ADDR_W, 16, Wishbone address width; must be 16 or 24 (a whole number of SPI bytes)
- TIMEOUT_CYC, 255, Wishbone watchdog limit in clk cycles (used only with the macro)
- clk  input  1  system clock; all logic is on its rising edge
- rst  input  1  synchronous, active-high reset
- spi_sclk_i  input  1  SPI clock; asynchronous to clk, at most clk/8
- spi_cs_n_i  input  1  SPI chip select, active low
- spi_mosi_i  input  1  SPI serial data in
- spi_miso_o  output  1  SPI serial data out
- spi_miso_oe_o  output  1  MISO drive enable; high only while CS is low
- wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone cycle, strobe, write enable
- wb_adr_o  output  ADDR_W  Wishbone address
- wb_dat_o  output  32  Wishbone write data
- wb_sel_o  output  4  Wishbone byte select
- wb_dat_i  input  32  Wishbone read data
- wb_ack_i, wb_err_i  input  1 each  Wishbone acknowledge, Wishbone error
- busy_o  output  1  high from frame decode until the Wishbone cycle ends
- err_o  output  1  sticky error flag; cleared on the next CS falling edge

## Operation
- Input conditioning: sclk, cs_n and mosi pass through 2-flop synchronizers. Edge detectors on the synchronized values produce rise, fall, cs_fall and cs_rise pulses.
- SPI mode 0, MSB first:
  - MOSI is sampled on the sclk rise pulse.
  - MISO is updated on the sclk fall pulse.
- Frame format:
  - CMD byte: bit7 = 1 for read, 0 for write. Bits6:4 must be 000. Bits3:0 give wb_sel.
  - ADDR: ADDR_W bits.
  - Write frame: 32 data bits follow ADDR.
  - Read frame: 8 dummy bits, then 32 data bits shifted out on MISO.
- States and transitions:
  - IDLE: on cs_fall go to CMD.
  - CMD: after 8 bits, if bits6:4 are not 000, set err_o and go to WAIT_CS. Otherwise go to ADDR.
  - ADDR: after ADDR_W bits, a write goes to WR_DATA. A read goes to RD_WB and starts the Wishbone read.
  - WR_DATA: after 32 bits go to WB_WR.
  - WB_WR: on ack or err go to WAIT_CS.
  - RD_WB: on ack, load wb_dat_i into the shift register and go to RD_DUMMY.
  - RD_DUMMY: go to RD_DATA when the 8th dummy bit is counted.
    - Reaching that count while still in RD_WB means the read was too slow: shift register becomes 0xFFFF_FFFF, err_o is set, and the Wishbone cycle continues to completion.
  - RD_DATA: shift out 32 bits, then go to WAIT_CS.
  - WAIT_CS: on cs_rise go to IDLE.
- cs_rise in any state before the Wishbone cycle starts aborts the frame; no Wishbone cycle is issued.
- cs_rise during a Wishbone cycle:
  - the cycle runs to ack/err;
  - then the FSM returns to IDLE.
- cs_fall while busy_o is high: the frame is ignored (all bits dropped) and err_o is set.
- A wb_err_i response sets err_o. Read data captured on an error is 0xFFFF_FFFF.
- The bit counter is 6 bits and resets at each field boundary; it never wraps inside a field.

## Timing
- Reset values:
  - all wb_* outputs 0;
  - spi_miso_o 0, spi_miso_oe_o 0;
  - busy_o 0, err_o 0;
  - FSM in IDLE.
- Reset in mid-frame or mid-cycle returns the block to IDLE on the next edge and drops wb_cyc_o immediately. The Wishbone slave must tolerate this.
- Edge latency: a pin transition produces its edge pulse 3 clk cycles later.
- Write: wb_cyc_o, wb_stb_o and wb_we_o rise 1 clk after the rise pulse of the last data bit.
- Read: wb_cyc_o and wb_stb_o rise 1 clk after the rise pulse of the last address bit.
- cyc and stb stay high until the clk in which ack or err is seen, and fall on the next clk.
- Single outstanding cycle only; no pipelining. wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o are held stable for the whole cycle.
- busy_o rises together with wb_cyc_o and falls together with it.
- Read slack: the Wishbone slave has 8 SCLK periods (at least 64 clk) to ack.

## Configuration
- SPI_WB_BRIDGE_TIMEOUT_EN defined: an 8-bit watchdog counts clk cycles while wb_cyc_o is high.
  - At TIMEOUT_CYC the bridge drops cyc/stb, sets err_o and treats the cycle as an error response.
  - The counter clears on every new cycle.
- Macro undefined: no watchdog is built; the bridge waits for ack or err indefinitely.

## Structure
- Shared package spi_wb_bridge_pkg holds:
  - the FSM state enum;
  - CMD bit positions (CMD_RD_BIT = 7, CMD_SEL_MSB = 3, CMD_RSVD = 6:4);
  - DUMMY_BITS = 8, DATA_BITS = 32;
  - RD_ERR_DATA = 32'hFFFF_FFFF.
- One sub-module, spi_wb_bridge_sync: the 2-flop synchronizer plus edge detector, instantiated for sclk, cs_n and mosi.

## Test plan
- Write CMD 0x0F, ADDR 0x1234, DATA 0xA5A5_5A5A -> one Wishbone write to adr 0x1234, sel 0xF, dat 0xA5A5_5A5A; err_o = 0.
- Read CMD 0x83, ADDR 0x0040, slave acks in 10 clk with 0xCAFE_F00D -> sel 0x3; MISO returns 0xCAFE_F00D after 8 dummy bits.
- CMD 0x10 (reserved bit set) -> no Wishbone cycle; err_o = 1 until the next cs_fall.
- CS deasserted after 20 data bits of a write -> no Wishbone cycle; FSM in IDLE; busy_o = 0.
- Read where the slave asserts wb_err_i -> MISO returns 0xFFFF_FFFF; err_o = 1.
- With SPI_WB_BRIDGE_TIMEOUT_EN defined, slave never acks -> cyc drops after 255 clk; err_o = 1. Then rst asserted mid-frame -> all outputs at reset values next clk.
